// File: rtl/cordic_arbiter.sv
// Two-requester round-robin front end for a shared CORDIC core with an in-order tag FIFO for result routing.
// Optional watchdog/flush enabled by defining CORDIC_ARB_TIMEOUT_EN.
module cordic_arbiter #(
   parameter int DATA_W      = 16,
   parameter int MAX_OUT     = 4,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [DATA_W-1:0] req_data0,
   input  logic [DATA_W-1:0] req_data1,
   output logic              cordic_in_tvalid,
   output logic [DATA_W-1:0] cordic_in_tdata,
   input  logic              cordic_out_tvalid,
   input  logic [DATA_W-1:0] cordic_out_tdata,
   output logic [1:0]        rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              busy,
   output logic              stray_err,
   output logic              timeout_err
);

   localparam int PTR_W = $clog2(MAX_OUT);
   localparam int CNT_W = $clog2(MAX_OUT + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

   typedef enum logic {ACTIVE, FLUSH} state_t;

   state_t             state_reg, state_next;
   logic               prio_reg;
   logic [CNT_W-1:0]   count_reg, count_next;
   logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic               tag_mem [MAX_OUT];
   logic               cordic_in_tvalid_reg;
   logic [DATA_W-1:0]  cordic_in_tdata_reg;
   logic [1:0]         rsp_valid_reg;
   logic [DATA_W-1:0]  rsp_data_reg;
   logic               stray_err_reg;

   logic               pop, stray, room, issue, grant_id, wd_fire;
   logic [1:0]         accept;

   // A result arriving this cycle frees a slot, so a full FIFO can still accept.
   always_comb begin
      pop        = cordic_out_tvalid && (count_reg != '0) && (state_reg == ACTIVE);
      stray      = cordic_out_tvalid && (count_reg == '0);
      room       = (count_reg != MAX_CNT) || pop;
      req_ready  = 2'b00;
      if (state_reg == ACTIVE && room) begin
         if (prio_reg == 1'b0) begin
            if (req_valid[0])      req_ready = 2'b01;
            else if (req_valid[1]) req_ready = 2'b10;
         end else begin
            if (req_valid[1])      req_ready = 2'b10;
            else if (req_valid[0]) req_ready = 2'b01;
         end
      end
      accept   = req_ready & req_valid;
      issue    = |accept;
      grant_id = accept[1];
   end

   always_comb begin
      count_next = count_reg;
      case ({issue, pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
      state_next = state_reg;
      if (state_reg == FLUSH)
         state_next = ACTIVE;
      else if (wd_fire)
         state_next = FLUSH;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg            <= ACTIVE;
         prio_reg             <= 1'b0;
         count_reg            <= '0;
         wr_ptr_reg           <= '0;
         rd_ptr_reg           <= '0;
         cordic_in_tvalid_reg <= 1'b0;
         cordic_in_tdata_reg  <= '0;
         rsp_valid_reg        <= 2'b00;
         rsp_data_reg         <= '0;
         stray_err_reg        <= 1'b0;
      end else begin
         state_reg            <= state_next;
         cordic_in_tvalid_reg <= issue;
         if (issue) begin
            cordic_in_tdata_reg <= grant_id ? req_data1 : req_data0;
            prio_reg            <= ~grant_id;
         end
         rsp_valid_reg <= 2'b00;
         if (pop) begin
            rsp_valid_reg <= tag_mem[rd_ptr_reg] ? 2'b10 : 2'b01;
            rsp_data_reg  <= cordic_out_tdata;
         end
         if (stray)
            stray_err_reg <= 1'b1;
         if (state_reg == FLUSH) begin
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
         end else begin
            count_reg <= count_next;
            if (issue) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
      end
   end

   // Tag storage has no reset; emptiness is tracked solely by count_reg.
   always_ff @(posedge clk) begin
      if (issue)
         tag_mem[wr_ptr_reg] <= grant_id;
   end

`ifdef CORDIC_ARB_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

   logic [WD_W-1:0] wd_cnt_reg;
   logic            timeout_err_reg;
   logic            wd_clear;

   always_comb begin
      wd_clear = pop || (issue && count_reg == '0);
      wd_fire  = !wd_clear && (count_reg != '0) && (state_reg == ACTIVE) &&
                 (wd_cnt_reg == WD_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt_reg      <= '0;
         timeout_err_reg <= 1'b0;
      end else begin
         if (state_reg == FLUSH || wd_clear || wd_fire)
            wd_cnt_reg <= '0;
         else if (count_reg != '0)
            wd_cnt_reg <= wd_cnt_reg + 1'b1;
         if (wd_fire)
            timeout_err_reg <= 1'b1;
      end
   end

   assign timeout_err = timeout_err_reg;
`else
   assign wd_fire     = 1'b0;
   assign timeout_err = 1'b0;
`endif

   assign cordic_in_tvalid = cordic_in_tvalid_reg;
   assign cordic_in_tdata  = cordic_in_tdata_reg;
   assign rsp_valid        = rsp_valid_reg;
   assign rsp_data         = rsp_data_reg;
   assign busy             = (count_reg != '0);
   assign stray_err        = stray_err_reg;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench for cordic_arbiter: arbitration, full/reopen, same-cycle issue/pop, stray, reset and watchdog.
module tb_cordic_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [15:0] req_data0, req_data1;
   logic        cordic_in_tvalid;
   logic [15:0] cordic_in_tdata;
   logic        cordic_out_tvalid;
   logic [15:0] cordic_out_tdata;
   logic [1:0]  rsp_valid;
   logic [15:0] rsp_data;
   logic        busy, stray_err, timeout_err;

   int total = 0;
   int bad   = 0;

   cordic_arbiter #(.DATA_W(16), .MAX_OUT(4), .TIMEOUT_CYC(64)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_data0(req_data0), .req_data1(req_data1),
      .cordic_in_tvalid(cordic_in_tvalid), .cordic_in_tdata(cordic_in_tdata),
      .cordic_out_tvalid(cordic_out_tvalid), .cordic_out_tdata(cordic_out_tdata),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .busy(busy), .stray_err(stray_err), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int n;
      rst = 1'b1; req_valid = 2'b00; req_data0 = '0; req_data1 = '0;
      cordic_out_tvalid = 1'b0; cordic_out_tdata = '0;
      tick(); tick(); tick();
      check("rst_ready", req_ready, 0);
      check("rst_in_tvalid", cordic_in_tvalid, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_stray", stray_err, 0);
      check("rst_timeout", timeout_err, 0);
      rst = 1'b0;

      // single request
      req_valid = 2'b01; req_data0 = 16'd4; #1;
      check("single_ready", req_ready, 2'b01);
      tick(); req_valid = 2'b00;
      check("single_in_tvalid", cordic_in_tvalid, 1);
      check("single_in_tdata", cordic_in_tdata, 4);
      check("single_busy", busy, 1);
      tick();
      check("single_in_pulse_end", cordic_in_tvalid, 0);
      cordic_out_tvalid = 1'b1; cordic_out_tdata = 16'd2;
      tick(); cordic_out_tvalid = 1'b0;
      check("single_rsp_valid", rsp_valid, 2'b01);
      check("single_rsp_data", rsp_data, 2);
      check("single_busy_idle", busy, 0);
      tick();
      check("single_rsp_pulse_end", rsp_valid, 0);
      $display("txn single done");

      // contention from a fresh priority pointer
      rst = 1'b1; tick(); rst = 1'b0;
      req_valid = 2'b11;
      for (int i = 0; i < 4; i++) begin
         req_data0 = 16'h100 + 16'(i); req_data1 = 16'h200 + 16'(i); #1;
         check($sformatf("cont_ready_%0d", i), req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
         tick();
         check($sformatf("cont_tdata_%0d", i), cordic_in_tdata,
               (i % 2 == 0) ? (32'h100 + i) : (32'h200 + i));
         $display("txn grant %0d", i);
      end
      req_valid = 2'b00;
      for (int j = 0; j < 4; j++) begin
         cordic_out_tvalid = 1'b1; cordic_out_tdata = 16'h50 + 16'(j);
         tick();
         check($sformatf("cont_rsp_valid_%0d", j), rsp_valid, (j % 2 == 0) ? 2'b01 : 2'b10);
         check($sformatf("cont_rsp_data_%0d", j), rsp_data, 32'h50 + j);
      end
      cordic_out_tvalid = 1'b0;
      tick();
      check("cont_busy_idle", busy, 0);

      // fill to MAX_OUT, fifth request blocked until a result arrives
      req_valid = 2'b01;
      for (int i = 0; i < 4; i++) begin
         req_data0 = 16'h30 + 16'(i); #1;
         check($sformatf("full_ready_%0d", i), req_ready, 2'b01);
         tick();
      end
      req_data0 = 16'h34; #1;
      check("full_ready_blocked", req_ready, 2'b00);
      check("full_busy", busy, 1);
      tick();
      check("full_no_issue", cordic_in_tvalid, 0);
      cordic_out_tvalid = 1'b1; cordic_out_tdata = 16'h77; #1;
      check("full_reopen_ready", req_ready, 2'b01);
      tick(); cordic_out_tvalid = 1'b0; req_valid = 2'b00;
      check("full_rsp_valid", rsp_valid, 2'b01);
      check("full_rsp_data", rsp_data, 32'h77);
      check("full_fifth_issue", cordic_in_tvalid, 1);
      check("full_fifth_tdata", cordic_in_tdata, 32'h34);
      for (int j = 0; j < 4; j++) begin
         cordic_out_tvalid = 1'b1; cordic_out_tdata = 16'h60 + 16'(j);
         tick();
         check($sformatf("full_drain_%0d", j), rsp_valid, 2'b01);
      end
      cordic_out_tvalid = 1'b0;
      check("full_drained_busy", busy, 0);
      $display("txn full done");

      // same-cycle issue and pop with two outstanding (tags 1 then 0)
      req_valid = 2'b10; tick();
      req_valid = 2'b01; tick();
      req_valid = 2'b10; cordic_out_tvalid = 1'b1; cordic_out_tdata = 16'h99; #1;
      check("simul_ready", req_ready, 2'b10);
      tick(); req_valid = 2'b00;
      check("simul_rsp_valid", rsp_valid, 2'b10);
      check("simul_rsp_data", rsp_data, 32'h99);
      cordic_out_tdata = 16'hA0; tick();
      check("simul_pop2_valid", rsp_valid, 2'b01);
      check("simul_pop2_busy", busy, 1);
      cordic_out_tdata = 16'hA1; tick();
      check("simul_pop3_valid", rsp_valid, 2'b10);
      check("simul_pop3_busy", busy, 0);
      cordic_out_tvalid = 1'b0;

      // stray result
      tick();
      cordic_out_tvalid = 1'b1; cordic_out_tdata = 16'hBB; tick(); cordic_out_tvalid = 1'b0;
      check("stray_err", stray_err, 1);
      check("stray_rsp_valid", rsp_valid, 0);
      tick();
      check("stray_sticky", stray_err, 1);

      // reset with three jobs outstanding
      req_valid = 2'b01; tick(); tick(); tick(); req_valid = 2'b00;
      check("midrst_busy_before", busy, 1);
      rst = 1'b1; tick();
      check("midrst_busy", busy, 0);
      check("midrst_stray", stray_err, 0);
      check("midrst_rsp_valid", rsp_valid, 0);
      check("midrst_in_tvalid", cordic_in_tvalid, 0);
      rst = 1'b0;
      cordic_out_tvalid = 1'b1; tick(); cordic_out_tvalid = 1'b0;
      check("midrst_late_stray", stray_err, 1);
      check("midrst_late_rsp", rsp_valid, 0);
      $display("txn stray/reset done");

      // watchdog
      rst = 1'b1; tick(); rst = 1'b0;
      req_valid = 2'b01; req_data0 = 16'h11; tick(); req_valid = 2'b00;
`ifdef CORDIC_ARB_TIMEOUT_EN
      n = 0;
      while (n < 80 && timeout_err !== 1'b1) begin
         tick();
         n++;
      end
      check("wd_fire_cycle", n, 64);
      req_valid = 2'b01; #1;
      check("wd_flush_ready", req_ready, 0);
      tick();
      check("wd_busy_cleared", busy, 0);
      check("wd_ready_back", req_ready, 2'b01);
      tick(); req_valid = 2'b00;
      check("wd_new_issue", cordic_in_tvalid, 1);
      check("wd_timeout_sticky", timeout_err, 1);
`else
      n = 0;
      while (n < 70) begin
         tick();
         n++;
      end
      check("nowd_timeout", timeout_err, 0);
      check("nowd_busy", busy, 1);
      cordic_out_tvalid = 1'b1; cordic_out_tdata = 16'h22; tick(); cordic_out_tvalid = 1'b0;
      check("nowd_rsp_valid", rsp_valid, 2'b01);
      check("nowd_busy_idle", busy, 0);
`endif
      $display("txn watchdog done");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
